// File: rtl/spi_frame_collector.sv
// spi_frame_collector: passive SPI frame monitor in the pclk domain.
// Oversamples sclk/csn/mosi/miso through 2-flop synchronizers and splits
// each chip-select frame into cmd / addr / write-data / read-data fields.
//
// Ports:
//   pclk, preset        system clock, async active-high reset
//   spi_clk, spi_csn    SPI clock (CPOL=0, rising-edge sample), chip select
//   spi_mosi, spi_miso  serial data lines
//   cfg_*_len           phase lengths, latched on CS fall (0 skips a phase)
//   frm_cmd/addr        captured command/address, right-justified
//   frm_mosi/miso_data  last DATA_W write/read bits, right-justified
//   frm_valid           1-cycle pulse, complete frame captured
//   frm_error           1-cycle pulse, frame aborted
//   frm_extra_edges     sclk edges seen after the last phase (with frm_valid)
//
// Build option: SPI_FRAME_COLLECTOR_TIMEOUT_EN adds a stalled-frame
// timeout of TIMEOUT_CYC pclk cycles without an sclk rise.

module spi_frame_collector #(
   parameter int DATA_W      = 32,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              spi_clk,
   input  logic              spi_csn,
   input  logic              spi_mosi,
   input  logic              spi_miso,
   input  logic [5:0]        cfg_cmd_len,
   input  logic [5:0]        cfg_addr_len,
   input  logic [15:0]       cfg_dummy_len,
   input  logic [15:0]       cfg_mosi_len,
   input  logic [15:0]       cfg_miso_len,
   output logic [DATA_W-1:0] frm_cmd,
   output logic [DATA_W-1:0] frm_addr,
   output logic [DATA_W-1:0] frm_mosi_data,
   output logic [DATA_W-1:0] frm_miso_data,
   output logic              frm_valid,
   output logic              frm_error,
   output logic              frm_extra_edges
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_TAIL
   } state_t;

   state_t r_state, w_nxt;

   // [0],[1] synchronizer, [2] previous synchronized value for edges
   logic [2:0] r_sclk_q;
   logic [2:0] r_csn_q;
   logic [1:0] r_mosi_q;
   logic [1:0] r_miso_q;

   logic [5:0]  r_cmd_len, r_addr_len;
   logic [15:0] r_dummy_len, r_mosi_len, r_miso_len;

   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_sh_cmd, r_sh_addr, r_sh_mosi, r_sh_miso;
   logic              r_extra;

   logic w_sclk_rise, w_cs_fall, w_cs_rise;
   logic w_start, w_adv, w_done, w_abort;
   logic w_timeout, w_wait_cs;
   logic [4:0] w_nz_cfg, w_nz_lat;

   // Next phase with nonzero length after cur; nz = {cmd,addr,dum,wr,rd}
   function automatic state_t f_next(input state_t cur,
                                     input logic [4:0] nz);
      logic [4:0] m;
      m = nz;
      case (cur)
         S_CMD:   m[4]   = 1'b0;
         S_ADDR:  m[4:3] = 2'b0;
         S_DUMMY: m[4:2] = 3'b0;
         S_WDATA: m[4:1] = 4'b0;
         S_RDATA: m      = 5'b0;
         S_TAIL:  m      = 5'b0;
         default: ;
      endcase
      if (m[4])      return S_CMD;
      else if (m[3]) return S_ADDR;
      else if (m[2]) return S_DUMMY;
      else if (m[1]) return S_WDATA;
      else if (m[0]) return S_RDATA;
      else           return S_TAIL;
   endfunction

   function automatic logic [CNT_W-1:0] f_len(
      input state_t s,
      input logic [5:0] cl, input logic [5:0] al,
      input logic [15:0] dl, input logic [15:0] wl,
      input logic [15:0] rl);
      case (s)
         S_CMD:   return CNT_W'(cl);
         S_ADDR:  return CNT_W'(al);
         S_DUMMY: return CNT_W'(dl);
         S_WDATA: return CNT_W'(wl);
         S_RDATA: return CNT_W'(rl);
         default: return '0;
      endcase
   endfunction

   assign w_sclk_rise = r_sclk_q[1] & ~r_sclk_q[2] & ~r_csn_q[1];
   assign w_cs_fall   = ~r_csn_q[1] &  r_csn_q[2];
   assign w_cs_rise   =  r_csn_q[1] & ~r_csn_q[2];

   assign w_nz_cfg = {|cfg_cmd_len, |cfg_addr_len, |cfg_dummy_len,
                      |cfg_mosi_len, |cfg_miso_len};
   assign w_nz_lat = {|r_cmd_len, |r_addr_len, |r_dummy_len,
                      |r_mosi_len, |r_miso_len};

   // Synchronizers. csn resets low so a reset with CS already low
   // (mid-frame) cannot fake a CS fall; a CS rise in IDLE is ignored.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_sclk_q <= '0;
         r_csn_q  <= '0;
         r_mosi_q <= '0;
         r_miso_q <= '0;
      end else begin
         r_sclk_q <= {r_sclk_q[1:0], spi_clk};
         r_csn_q  <= {r_csn_q[1:0], spi_csn};
         r_mosi_q <= {r_mosi_q[0], spi_mosi};
         r_miso_q <= {r_miso_q[0], spi_miso};
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt   = r_state;
      w_start = 1'b0;
      w_adv   = 1'b0;
      w_done  = 1'b0;
      w_abort = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cs_fall && !w_wait_cs) begin
               w_start = 1'b1;
               w_nxt   = f_next(S_IDLE, w_nz_cfg);
            end
         end
         S_TAIL: begin
            if (w_cs_rise) begin
               w_done = 1'b1;
               w_nxt  = S_IDLE;
            end
         end
         default: begin
            if (w_cs_rise) begin
               w_abort = 1'b1;
               w_nxt   = S_IDLE;
            end else if (w_sclk_rise && r_cnt == CNT_W'(1)) begin
               w_adv = 1'b1;
               w_nxt = f_next(r_state, w_nz_lat);
            end
         end
      endcase
      if (w_timeout) begin
         w_done  = 1'b0;
         w_adv   = 1'b0;
         w_abort = 1'b1;
         w_nxt   = S_IDLE;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_cmd_len       <= '0;
         r_addr_len      <= '0;
         r_dummy_len     <= '0;
         r_mosi_len      <= '0;
         r_miso_len      <= '0;
         r_cnt           <= '0;
         r_sh_cmd        <= '0;
         r_sh_addr       <= '0;
         r_sh_mosi       <= '0;
         r_sh_miso       <= '0;
         r_extra         <= 1'b0;
         frm_cmd         <= '0;
         frm_addr        <= '0;
         frm_mosi_data   <= '0;
         frm_miso_data   <= '0;
         frm_valid       <= 1'b0;
         frm_error       <= 1'b0;
         frm_extra_edges <= 1'b0;
      end else begin
         frm_valid <= w_done;
         frm_error <= w_abort;
         if (w_start) begin
            r_cmd_len   <= cfg_cmd_len;
            r_addr_len  <= cfg_addr_len;
            r_dummy_len <= cfg_dummy_len;
            r_mosi_len  <= cfg_mosi_len;
            r_miso_len  <= cfg_miso_len;
            r_cnt       <= f_len(w_nxt, cfg_cmd_len, cfg_addr_len,
                                 cfg_dummy_len, cfg_mosi_len,
                                 cfg_miso_len);
            r_sh_cmd    <= '0;
            r_sh_addr   <= '0;
            r_sh_mosi   <= '0;
            r_sh_miso   <= '0;
            r_extra     <= 1'b0;
         end else if (w_sclk_rise && r_state != S_IDLE) begin
            case (r_state)
               S_CMD:
                  r_sh_cmd  <= {r_sh_cmd[DATA_W-2:0], r_mosi_q[1]};
               S_ADDR:
                  r_sh_addr <= {r_sh_addr[DATA_W-2:0], r_mosi_q[1]};
               S_WDATA:
                  r_sh_mosi <= {r_sh_mosi[DATA_W-2:0], r_mosi_q[1]};
               S_RDATA:
                  r_sh_miso <= {r_sh_miso[DATA_W-2:0], r_miso_q[1]};
               S_TAIL:
                  r_extra   <= 1'b1;
               default: ;
            endcase
            if (r_state != S_TAIL) begin
               if (w_adv)
                  r_cnt <= f_len(w_nxt, r_cmd_len, r_addr_len,
                                 r_dummy_len, r_mosi_len, r_miso_len);
               else
                  r_cnt <= r_cnt - CNT_W'(1);
            end
         end
         if (w_done) begin
            frm_cmd         <= r_sh_cmd;
            frm_addr        <= r_sh_addr;
            frm_mosi_data   <= r_sh_mosi;
            frm_miso_data   <= r_sh_miso;
            frm_extra_edges <= r_extra;
         end
      end
   end

`ifdef SPI_FRAME_COLLECTOR_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_wait_cs;

   assign w_timeout = (r_state != S_IDLE) && !r_csn_q[1] &&
                      !w_sclk_rise &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign w_wait_cs = r_wait_cs;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_to_cnt  <= '0;
         r_wait_cs <= 1'b0;
      end else begin
         if (r_state == S_IDLE || r_csn_q[1] || w_sclk_rise)
            r_to_cnt <= '0;
         else
            r_to_cnt <= r_to_cnt + TO_W'(1);
         // after a timeout the stalled frame's CS must rise first
         if (w_timeout)
            r_wait_cs <= 1'b1;
         else if (r_csn_q[1])
            r_wait_cs <= 1'b0;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_wait_cs = 1'b0;
`endif

endmodule
